// File: rtl/gpr_multiport.sv
// ============================================================================
// Module   : gpr_multiport
// Brief    : Multi-read, dual-write GPR file with pending scoreboard and
//            sequential clear sweep. Optional forwarding: YUTORINA_GPR_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear_request,
  output logic                             ready,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_pending,
  input  logic                             write0_enable,
  input  logic [ADDR_WIDTH-1:0]            write0_address,
  input  logic [DATA_WIDTH-1:0]            write0_data,
  input  logic                             write1_enable,
  input  logic [ADDR_WIDTH-1:0]            write1_address,
  input  logic [DATA_WIDTH-1:0]            write1_data,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_address
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic [ADDR_WIDTH-1:0]   index_q;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]        pending_q;
  logic [DEPTH-1:0]        pending_d;

  logic w0_valid;
  logic w1_valid;
  logic rsv_valid;

  assign w0_valid  = write0_enable && (write0_address != '0);
  assign w1_valid  = write1_enable && (write1_address != '0);
  assign rsv_valid = reserve_enable && (reserve_address != '0);

  // Reserve is applied after the write clears: it marks a newer producer.
  always_comb begin
    pending_d = pending_q;
    if (w0_valid) pending_d[write0_address] = 1'b0;
    if (w1_valid) pending_d[write1_address] = 1'b0;
    if (rsv_valid) pending_d[reserve_address] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      ready_q   <= 1'b0;
      index_q   <= '0;
      pending_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          regs_q[index_q] <= '0;
          index_q         <= index_q + 1'b1;
          if (index_q == {ADDR_WIDTH{1'b1}}) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (clear_request) begin
            state_q   <= ST_CLEAR;
            ready_q   <= 1'b0;
            index_q   <= '0;
            pending_q <= '0;
          end else begin
            // Port 1 is written last so it wins an address collision.
            if (w0_valid) regs_q[write0_address] <= write0_data;
            if (w1_valid) regs_q[write1_address] <= write1_data;
            pending_q <= pending_d;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ready_q <= 1'b0;
          index_q <= '0;
        end
      endcase
    end
  end

  assign ready = ready_q;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_pend;

    assign rd_addr = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_data = '0;
      rd_pend = 1'b0;
      if (ready_q && (rd_addr != '0)) begin
        rd_data = regs_q[rd_addr];
        rd_pend = pending_q[rd_addr];
`ifdef YUTORINA_GPR_BYPASS_EN
        if (w1_valid && (write1_address == rd_addr)) begin
          rd_data = write1_data;
          rd_pend = rsv_valid && (reserve_address == rd_addr);
        end else if (w0_valid && (write0_address == rd_addr)) begin
          rd_data = write0_data;
          rd_pend = rsv_valid && (reserve_address == rd_addr);
        end
`endif
      end
    end

    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    assign read_pending[k]                       = rd_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_gpr_multiport.sv
// ============================================================================
// Module   : tb_gpr_multiport
// Brief    : Directed self-checking bench for gpr_multiport (2 read ports).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_multiport;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_request;
  logic        ready;
  logic [9:0]  read_address;
  logic [63:0] read_data;
  logic [1:0]  read_pending;
  logic        write0_enable;
  logic [4:0]  write0_address;
  logic [31:0] write0_data;
  logic        write1_enable;
  logic [4:0]  write1_address;
  logic [31:0] write1_data;
  logic        reserve_enable;
  logic [4:0]  reserve_address;

  int n_assert = 0;
  int n_fail   = 0;
  int n_edges;

  gpr_multiport #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .READ_PORTS(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .clear_request   (clear_request),
    .ready           (ready),
    .read_address    (read_address),
    .read_data       (read_data),
    .read_pending    (read_pending),
    .write0_enable   (write0_enable),
    .write0_address  (write0_address),
    .write0_data     (write0_data),
    .write1_enable   (write1_enable),
    .write1_address  (write1_address),
    .write1_data     (write1_data),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic idle_inputs();
    clear_request  = 1'b0;
    write0_enable  = 1'b0;
    write1_enable  = 1'b0;
    reserve_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    read_address    = '0;
    write0_address  = '0;
    write0_data     = '0;
    write1_address  = '0;
    write1_data     = '0;
    reserve_address = '0;

    // Power-up reset and first sweep
    tick(); tick();
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_data", read_data, 64'd0);
    check("reset_pending", {62'd0, read_pending}, 64'd0);
    reset = 1'b0;
    wait_sweep(n_edges);
    check("first_sweep_len", 64'(n_edges), 64'd32);

    // Preload 5 and 31, then reset and sweep must zero them
    write0_enable = 1'b1; write0_address = 5'd5;  write0_data = 32'hDEADBEEF;
    write1_enable = 1'b1; write1_address = 5'd31; write1_data = 32'hDEADBEEF;
    read_address  = {5'd31, 5'd5};
    tick();
    idle_inputs();
    check("preload", read_data, {32'hDEADBEEF, 32'hDEADBEEF});
    reset = 1'b1;
    tick(); tick();
    check("reset2_ready", {63'd0, ready}, 64'd0);
    check("reset2_data", read_data, 64'd0);
    reset = 1'b0;
    wait_sweep(n_edges);
    check("sweep_len", 64'(n_edges), 64'd32);
    check("swept_5_31", read_data, 64'd0);

    // Dual-write collision: port 1 wins
    write0_enable = 1'b1; write0_address = 5'd7; write0_data = 32'h11111111;
    write1_enable = 1'b1; write1_address = 5'd7; write1_data = 32'h22222222;
    read_address  = {5'd0, 5'd7};
    tick();
    idle_inputs();
    check("collision", read_data, {32'd0, 32'h22222222});

    // Register 0 writes and reserves are ignored
    write0_enable = 1'b1; write0_address = 5'd0; write0_data = 32'h5;
    reserve_enable = 1'b1; reserve_address = 5'd0;
    read_address  = {5'd0, 5'd0};
    tick();
    idle_inputs();
    check("reg0_data", read_data, 64'd0);
    check("reg0_pending", {62'd0, read_pending}, 64'd0);

    // Scoreboard: reserve, write clears, reserve+write keeps pending
    reserve_enable = 1'b1; reserve_address = 5'd9;
    read_address   = {5'd0, 5'd9};
    tick();
    idle_inputs();
    check("reserve_set", {62'd0, read_pending}, 64'd1);
    write0_enable = 1'b1; write0_address = 5'd9; write0_data = 32'h3;
    #1;
`ifdef YUTORINA_GPR_BYPASS_EN
    check("bypass_pending_clr", {62'd0, read_pending}, 64'd0);
`else
    check("pending_before_write", {62'd0, read_pending}, 64'd1);
`endif
    tick();
    idle_inputs();
    check("write_clears_pending", {62'd0, read_pending}, 64'd0);
    check("write9_data", read_data, {32'd0, 32'h3});
    write1_enable  = 1'b1; write1_address = 5'd9; write1_data = 32'h4;
    reserve_enable = 1'b1; reserve_address = 5'd9;
    tick();
    idle_inputs();
    check("reserve_beats_write", {62'd0, read_pending}, 64'd1);
    check("write9_data2", read_data, {32'd0, 32'h4});

    // Same-cycle forwarding on read port 1
    read_address  = {5'd12, 5'd0};
    write0_enable = 1'b1; write0_address = 5'd12; write0_data = 32'hCAFE0001;
    #1;
`ifdef YUTORINA_GPR_BYPASS_EN
    check("bypass_same_cycle", read_data, {32'hCAFE0001, 32'd0});
`else
    check("no_bypass_same_cycle", read_data, 64'd0);
`endif
    tick();
    idle_inputs();
    check("write12_next_cycle", read_data, {32'hCAFE0001, 32'd0});

    // Mid-operation clear discards a same-cycle write
    write0_enable  = 1'b1; write0_address = 5'd3; write0_data = 32'hA5;
    reserve_enable = 1'b1; reserve_address = 5'd3;
    read_address   = {5'd4, 5'd3};
    tick();
    idle_inputs();
    check("reg3_loaded", read_data, {32'd0, 32'hA5});
    check("reg3_pending", {62'd0, read_pending}, 64'd1);
    clear_request = 1'b1;
    write0_enable = 1'b1; write0_address = 5'd4; write0_data = 32'h77;
    tick();
    idle_inputs();
    check("clear_ready_low", {63'd0, ready}, 64'd0);
    check("clear_data_forced", read_data, 64'd0);
    wait_sweep(n_edges);
    check("clear_sweep_len", 64'(n_edges), 64'd32);
    check("cleared_3_4", read_data, 64'd0);
    check("cleared_pending", {62'd0, read_pending}, 64'd0);

    // Reset at sweep index 10 restarts the sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midsweep_ready_low", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_sweep(n_edges);
    check("restart_sweep_len", 64'(n_edges), 64'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpr_multiport.md
# gpr_multiport

Parametrised general-purpose register file for the Yutorina core. It is the successor to the fixed two-read/one-write GPR and sits between the decode stage (reads) and the writeback stage (writes). Over the plain storage it adds:
- configurable read-port count;
- a second write port;
- a per-register pending scoreboard for hazard detection;
- a sequential clear sweep that zeroes the whole array after reset or on request.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth DEPTH = 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (1..4)

Ports:
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- clear_request  in  1  one-cycle pulse that restarts the clear sweep
- ready  out  1  1 = sweep finished, file operational
- read_address  in  READ_PORTS*ADDR_WIDTH  port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  READ_PORTS*DATA_WIDTH  port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- read_pending  out  READ_PORTS  port k: addressed register has an outstanding reservation
- write0_enable  in  1  write port 0 strobe
- write0_address  in  ADDR_WIDTH  write port 0 target register
- write0_data  in  DATA_WIDTH  write port 0 data
- write1_enable  in  1  write port 1 strobe
- write1_address  in  ADDR_WIDTH  write port 1 target register
- write1_data  in  DATA_WIDTH  write port 1 data
- reserve_enable  in  1  mark reserve_address as pending (issue of a producer)
- reserve_address  in  ADDR_WIDTH  register to reserve

## Operation
State machine with two states, CLEAR and READY. The sweep index is ADDR_WIDTH bits.

CLEAR:
- Each clock, regs[index] <= 0 and index <= index + 1.
- After the edge that clears DEPTH-1, state <= READY.
- ready = 0 throughout.
- Write and reserve inputs are ignored.
- read_data is forced to 0 and read_pending to 0.
- clear_request is ignored.

READY:
- ready = 1.
- Write port p writes when writeP_enable = 1 and writeP_address != 0.
- Register 0 always reads 0. Writes, reserves and pending for address 0 are ignored and read as 0.
- Both write ports targeting the same address: port 1 wins; both writes clear that address's pending bit.
- Reserve sets pending[reserve_address] at the edge.
- A write clears pending[write address] at the edge.
- Reserve and write to the same address in the same cycle: pending ends at 1, because the reserve marks a newer producer.
- clear_request = 1: state <= CLEAR, index <= 0, all pending bits <= 0. Any write or reserve in that cycle is discarded.

Reset:
- While reset = 1 at an edge: state <= CLEAR, index <= 0, all pending bits <= 0. Register contents are not touched by reset itself.
- Reset asserted mid-sweep restarts the sweep at index 0.
- Output values during/after reset: ready = 0, read_data = 0, read_pending = 0.

Reads:
- Reads are combinational from read_address.
- Without bypass (see Configuration), a write is visible on reads from the cycle after its edge.

## Timing
- Read latency: 0 cycles (combinational). Write-to-read latency: 1 cycle (0 cycles with bypass).
- Sweep length: exactly DEPTH clock edges with reset = 0. ready rises after the DEPTH-th such edge.
- Pending set/clear takes effect 1 edge after the request.
- clear_request in READY drops ready to 0 after that edge. Recovery is the same DEPTH edges as after reset.

## Configuration
Macro: `YUTORINA_GPR_BYPASS_EN`.

Defined:
- Read port k compares its address against both write ports in the current cycle, in READY state only.
- On a match with a nonzero address and enable = 1, read_data returns the write data; port 1 has priority over port 0.
- read_pending[k] = 0 for that match unless reserve_enable targets the same address in that cycle.

Undefined:
- No forwarding. read_data comes from stored contents only.
- read_pending reflects the registered pending bits only.

## Test plan
- Sweep after reset: preload regs 5 and 31 with 0xDEADBEEF, assert reset 2 cycles, release -> ready = 0 for 32 edges, ready = 1 after the 32nd, reg5 = reg31 = 0.
- Dual-write collision: write0 (7, 0x11111111) and write1 (7, 0x22222222) in the same cycle -> next cycle read port 0 at 7 returns 0x22222222. A write of 0x5 to address 0 -> reads of 0 return 0.
- Scoreboard sequence:
  - reserve 9 -> read_pending = 1 next cycle;
  - write 9 = 0x3 -> pending = 0 after that edge;
  - reserve and write 9 in the same cycle -> pending stays 1.
- Bypass: write0 (12, 0xCAFE0001) while read port 1 addresses 12 -> same cycle returns 0xCAFE0001 with the macro defined, the old value without it. Both builds show 0xCAFE0001 next cycle.
- Mid-operation clear: in READY with reg 3 = 0xA5 and pending[3] = 1, pulse clear_request together with write (4, 0x77) -> ready = 0, write discarded, after 32 edges reg3 = reg4 = 0 and pending[3] = 0.
- Reset mid-sweep: assert reset at sweep index 10 -> the sweep restarts at 0 and ready is reached 32 edges after release.
